phase_arbiter: RTL

Signal-phase scheduler for the four-approach intersection. It decides which approach (N, E, S, W) gets green next from the live per-lane queue counts. It sizes that green time, inserts yellow and all-red clearance, and services latched pedestrian requests and emergency pre-emption. It sits between the lane-count/request inputs and the light drivers, and replaces fixed-rotation sequencing.

---
 rtl/phase_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/phase_arbiter.sv
// phase_arbiter: four-approach signal-phase scheduler with demand-sized greens, clearance,
// emergency pre-emption and an optional pedestrian walk phase (enabled by PHASE_ARB_PED_EN).
module phase_arbiter #(
  parameter int unsigned MIN_GREEN   = 4,
  parameter int unsigned MAX_GREEN   = 20,
  parameter int unsigned NIGHT_GREEN = 6,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1,
  parameter int unsigned PED_TIME    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] laneCounts,
  input  logic        nightMode,
  input  logic        pedReq,
  input  logic        emgReq,
  input  logic [7:0]  emgLane,
  output logic [7:0]  greenMask,
  output logic [7:0]  yellowMask,
  output logic        pedWalk,
  output logic [1:0]  phase,
  output logic [7:0]  countdown,
  output logic        emgActive
);

  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_PED    = 3'd3,
    ST_EMG    = 3'd4
  } state_t;

  localparam logic [7:0] YEL_LOAD   = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] AR_LOAD    = 8'(ALLRED_TIME - 1);
  localparam logic [7:0] PED_LOAD   = 8'(PED_TIME - 1);
  localparam logic [7:0] NIGHT_LOAD = 8'(NIGHT_GREEN - 1);
  localparam logic [9:0] MIN_G10    = 10'(MIN_GREEN);
  localparam logic [9:0] MAX_G10    = 10'(MAX_GREEN);

`ifdef PHASE_ARB_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] countdown_q, countdown_d;
  logic [7:0] green_mask_q, green_mask_d;
  logic [7:0] yellow_mask_q, yellow_mask_d;
  logic       ped_walk_q, ped_walk_d;
  logic       emg_active_q, emg_active_d;
  logic       ped_go;

  // Per-approach demand: 9-bit sum of the two lane counts of each approach.
  logic [8:0] approach_sum [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sum
      assign approach_sum[gi] = {1'b0, laneCounts[16*gi+8 +: 8]} + {1'b0, laneCounts[16*gi +: 8]};
    end
  endgenerate

  // Emergency lane decode: highest set bit wins, lane pair gives the approach.
  logic [2:0] emg_bit;
  logic       emg_valid;
  logic [1:0] emg_dir;
  always_comb begin
    emg_bit = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (emgLane[i]) emg_bit = 3'(i);
    end
  end
  assign emg_valid = emgReq & (|emgLane);
  assign emg_dir   = emg_bit[2:1];

  // Largest demand wins; strict compare keeps the earliest approach in round-robin order.
  logic [1:0] arb_dir, arb_cand;
  logic [8:0] arb_sum;
  always_comb begin
    arb_dir  = phase_q + 2'd1;
    arb_cand = arb_dir;
    arb_sum  = approach_sum[arb_dir];
    for (int k = 1; k < 4; k++) begin
      arb_cand = phase_q + 2'd1 + 2'(k);
      if (approach_sum[arb_cand] > arb_sum) begin
        arb_dir = arb_cand;
        arb_sum = approach_sum[arb_cand];
      end
    end
  end

  logic [9:0] day_green;
  logic [7:0] green_load;
  always_comb begin
    day_green = MIN_G10 + {3'b000, arb_sum[8:2]};
    if (day_green > MAX_G10) day_green = MAX_G10;
    green_load = nightMode ? NIGHT_LOAD : 8'(day_green - 10'd1);
  end

`ifdef PHASE_ARB_PED_EN
  logic ped_pending_q, ped_pending_d;
  assign ped_go = ped_pending_q;
  always_comb begin
    ped_pending_d = ped_pending_q | pedReq;
    if (state_q == ST_ALLRED && state_d == ST_PED) ped_pending_d = 1'b0;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = pedReq;
  assign ped_go         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    countdown_d = (countdown_q == 8'd0) ? 8'd0 : countdown_q - 8'd1;
    case (state_q)
      ST_ALLRED: begin
        if (countdown_q == 8'd0) begin
          if (emg_valid) begin
            state_d     = ST_EMG;
            phase_d     = emg_dir;
            countdown_d = 8'd0;
          end else if (ped_go) begin
            state_d     = ST_PED;
            countdown_d = PED_LOAD;
          end else begin
            state_d     = ST_GREEN;
            phase_d     = arb_dir;
            countdown_d = green_load;
          end
        end
      end
      ST_GREEN: begin
        if (emg_valid && emg_dir == phase_q) begin
          state_d     = ST_EMG;
          countdown_d = 8'd0;
        end else if (emg_valid || countdown_q == 8'd0) begin
          state_d     = ST_YELLOW;
          countdown_d = YEL_LOAD;
        end
      end
      ST_YELLOW: begin
        if (countdown_q == 8'd0) begin
          state_d     = ST_ALLRED;
          countdown_d = AR_LOAD;
        end
      end
      ST_PED: begin
        if (emg_valid || countdown_q == 8'd0) begin
          state_d     = ST_ALLRED;
          countdown_d = AR_LOAD;
        end
      end
      ST_EMG: begin
        countdown_d = 8'd0;
        // Release or a move to another approach both clear through yellow and all-red.
        if (!emg_valid || emg_dir != phase_q) begin
          state_d     = ST_YELLOW;
          countdown_d = YEL_LOAD;
        end
      end
      default: begin
        state_d     = ST_ALLRED;
        countdown_d = AR_LOAD;
      end
    endcase
  end

  always_comb begin
    green_mask_d  = 8'h00;
    yellow_mask_d = 8'h00;
    if (state_d == ST_GREEN || state_d == ST_EMG) green_mask_d = 8'h03 << {phase_d, 1'b0};
    if (state_d == ST_YELLOW) yellow_mask_d = 8'h03 << {phase_d, 1'b0};
    ped_walk_d   = PED_EN && (state_d == ST_PED);
    emg_active_d = (state_d == ST_EMG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ALLRED;
      phase_q       <= 2'd3;
      countdown_q   <= AR_LOAD;
      green_mask_q  <= 8'h00;
      yellow_mask_q <= 8'h00;
      ped_walk_q    <= 1'b0;
      emg_active_q  <= 1'b0;
`ifdef PHASE_ARB_PED_EN
      ped_pending_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      countdown_q   <= countdown_d;
      green_mask_q  <= green_mask_d;
      yellow_mask_q <= yellow_mask_d;
      ped_walk_q    <= ped_walk_d;
      emg_active_q  <= emg_active_d;
`ifdef PHASE_ARB_PED_EN
      ped_pending_q <= ped_pending_d;
`endif
    end
  end

  assign greenMask  = green_mask_q;
  assign yellowMask = yellow_mask_q;
  assign pedWalk    = ped_walk_q;
  assign phase      = phase_q;
  assign countdown  = countdown_q;
  assign emgActive  = emg_active_q;

endmodule
